// File: rtl/frac_pwm_pkg.sv
// frac_pwm_pkg: shared widths, state encoding and period clamp for frac_phase_gen
package frac_pwm_pkg;
  localparam int DEF_WIDTH_TMR  = 21;
  localparam int DEF_WIDTH_FRAC = 10;
  localparam int DEF_WIDTH_ERR  = 22;
  localparam int DEF_MIN_PERIOD = 4;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/frac_accum.sv
// frac_accum: fractional period accumulator, carry adds one cycle to the current period
module frac_accum #(
  parameter int WIDTH_FRAC = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  step,
  input  logic [WIDTH_FRAC-1:0] frac,
  output logic                  carry,
  output logic [WIDTH_FRAC-1:0] acc
);
  logic [WIDTH_FRAC-1:0] r_acc;
  logic [WIDTH_FRAC:0]   w_sum;
  assign w_sum = {1'b0, r_acc} + {1'b0, frac};
  assign carry = w_sum[WIDTH_FRAC];
  assign acc   = r_acc;
  // advance on every period load, restart from zero whenever the generator idles
  always_ff @(posedge clk)
    if (reset || clr) r_acc <= '0;
    else if (step) r_acc <= w_sum[WIDTH_FRAC-1:0];
endmodule

// File: rtl/frac_phase_gen.sv
// frac_phase_gen: fractional-period square wave generator with one-shot period correction
module frac_phase_gen
  import frac_pwm_pkg::*;
#(
  parameter int WIDTH_TMR  = DEF_WIDTH_TMR,
  parameter int WIDTH_FRAC = DEF_WIDTH_FRAC,
  parameter int WIDTH_ERR  = DEF_WIDTH_ERR,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [WIDTH_TMR-1:0]        period_int,
  input  logic [WIDTH_FRAC-1:0]       period_frac,
  input  logic signed [WIDTH_ERR-1:0] corr,
  input  logic                        corr_valid,
  output logic                        corr_ack,
  output logic                        fb_phase,
  output logic                        period_start,
  output logic                        sat
);
  state_t r_state, w_state_nx;
  logic [WIDTH_TMR-1:0]        r_cnt, r_th, w_len, w_th;
  logic signed [WIDTH_ERR-1:0] r_corr;
  logic signed [WIDTH_TMR+1:0] w_l, w_corr_ext;
  logic                        r_pend, r_fb, r_ps, r_sat, r_ack;
  logic                        w_load, w_carry, w_sat;
  logic [WIDTH_FRAC-1:0]       w_acc;
  int                          w_lc;
  frac_accum #(.WIDTH_FRAC(WIDTH_FRAC)) u_acc (
    .clk(clk), .reset(reset), .clr(!enable), .step(w_load),
    .frac(period_frac), .carry(w_carry), .acc(w_acc)
  );
  assign w_load       = enable && (r_state == IDLE || r_cnt == '0);
  assign w_corr_ext   = r_pend ? {{(WIDTH_TMR+2-WIDTH_ERR){r_corr[WIDTH_ERR-1]}}, r_corr} : '0;
  assign w_l          = $signed({2'b00, period_int}) + $signed({{(WIDTH_TMR+1){1'b0}}, w_carry}) + w_corr_ext;
  assign w_lc         = clamp(int'(w_l), MIN_PERIOD, (1 << WIDTH_TMR) - 1);
  assign w_sat        = w_lc != int'(w_l);
  assign w_len        = w_lc[WIDTH_TMR-1:0];
  assign w_th         = w_len - (w_len >> 1) - 1'b1;
  assign corr_ack     = r_ack;
  assign fb_phase     = r_fb;
  assign period_start = r_ps;
  assign sat          = r_sat;
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_state_nx;
  // run while enabled, drop to idle the moment enable falls
  always_comb
    w_state_nx = enable ? RUN : IDLE;
  // down-counter, high-phase threshold and registered outputs; cnt counts L-1..0
  always_ff @(posedge clk)
    if (reset || !enable) begin
      r_cnt  <= '0;
      r_th   <= '0;
      r_pend <= 1'b0;
      r_fb   <= 1'b0;
      r_ps   <= 1'b0;
      r_sat  <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_cnt  <= w_load ? w_len - 1'b1 : r_cnt - 1'b1;
      r_th   <= w_load ? w_th : r_th;
      r_fb   <= w_load || (r_cnt - 1'b1 > r_th);
      r_ps   <= w_load;
      r_sat  <= w_load && w_sat;
      r_ack  <= w_load && r_pend;
      r_pend <= corr_valid || (r_pend && !w_load);
    end
  // latest correction wins until it is consumed by a load
  always_ff @(posedge clk)
    if (reset) r_corr <= '0;
    else if (corr_valid) r_corr <= corr;
  // the accumulator must already be cleared whenever the generator sits idle
  always_ff @(posedge clk)
    if (!reset && r_state == IDLE) assert (w_acc == '0);
endmodule

// File: tb/tb_frac_phase_gen.sv
// tb_frac_phase_gen: directed vector bench for frac_phase_gen
module tb_frac_phase_gen;
  localparam int LIM = 3000;
  logic clk = 1'b0;
  logic reset, enable, corr_valid;
  logic [20:0] period_int;
  logic [9:0]  period_frac;
  logic signed [21:0] corr;
  logic corr_ack, fb_phase, period_start, sat;
  int total = 0;
  int bad = 0;
  typedef struct {
    int pint1; int pint2; int frac; int cv; int corr;
    int len1; int hi1; int sat1; int len2; int hi2; int ack2; int sat2;
  } vec_t;
  vec_t vt[7];
  frac_phase_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .period_int(period_int),
    .period_frac(period_frac), .corr(corr), .corr_valid(corr_valid),
    .corr_ack(corr_ack), .fb_phase(fb_phase), .period_start(period_start), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic meas(output int len, output int hi);
    len = 0;
    hi = 0;
    do begin
      hi += int'(fb_phase);
      len++;
      step();
    end while (!period_start && len < LIM);
  endtask
  task automatic wait_start();
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < LIM);
    chk("wait_start", int'(period_start), 1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    corr_valid = 1'b0;
    corr = '0;
    period_frac = '0;
    step();
    step();
    chk("reset_outs", int'({period_start, fb_phase, corr_ack, sat}), 0);
    reset = 1'b0;
  endtask
  initial begin
    int len, hi;
    int exp_f[8];
    vt[0] = '{10, 10, 0, 0, 0, 10, 5, 0, 10, 5, 0, 0};
    vt[1] = '{100, 100, 0, 1, -3, 100, 50, 0, 97, 48, 1, 0};
    vt[2] = '{5, 5, 0, 1, -20, 5, 2, 0, 4, 2, 1, 1};
    vt[3] = '{2, 2, 0, 0, 0, 4, 2, 1, 4, 2, 0, 1};
    vt[4] = '{12, 2097150, 0, 1, 10, 12, 6, 0, 0, 0, 1, 1};
    vt[5] = '{7, 9, 0, 0, 0, 7, 3, 0, 9, 4, 0, 0};
    vt[6] = '{10, 10, 0, 1, 3, 10, 5, 0, 13, 6, 1, 0};
    exp_f = '{10, 10, 10, 11, 10, 10, 10, 11};
    period_int = '0;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      period_int = 21'(vt[i].pint1);
      period_frac = 10'(vt[i].frac);
      corr = 22'(vt[i].corr);
      corr_valid = vt[i].cv != 0;
      enable = 1'b1;
      step();
      corr_valid = 1'b0;
      period_int = 21'(vt[i].pint2);
      chk($sformatf("v%0d_first_start", i), int'({period_start, fb_phase}), 3);
      chk($sformatf("v%0d_sat1", i), int'(sat), vt[i].sat1);
      chk($sformatf("v%0d_ack1", i), int'(corr_ack), 0);
      meas(len, hi);
      chk($sformatf("v%0d_len1", i), len, vt[i].len1);
      chk($sformatf("v%0d_hi1", i), hi, vt[i].hi1);
      chk($sformatf("v%0d_ack2", i), int'(corr_ack), vt[i].ack2);
      chk($sformatf("v%0d_sat2", i), int'(sat), vt[i].sat2);
      if (vt[i].len2 != 0) begin
        meas(len, hi);
        chk($sformatf("v%0d_len2", i), len, vt[i].len2);
        chk($sformatf("v%0d_hi2", i), hi, vt[i].hi2);
        chk($sformatf("v%0d_ack3", i), int'(corr_ack), 0);
      end
    end
    do_reset();
    period_int = 21'd10;
    period_frac = 10'd256;
    enable = 1'b1;
    step();
    chk("frac_start", int'(period_start), 1);
    for (int i = 0; i < 8; i++) begin
      meas(len, hi);
      chk($sformatf("frac_len%0d", i), len, exp_f[i]);
    end
    do_reset();
    period_int = 21'd100;
    enable = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    corr = 22'sd5;
    corr_valid = 1'b1;
    step();
    corr = 22'sd7;
    step();
    corr_valid = 1'b0;
    wait_start();
    chk("ovw_ack", int'(corr_ack), 1);
    meas(len, hi);
    chk("ovw_len", len, 107);
    chk("ovw_ack_next", int'(corr_ack), 0);
    meas(len, hi);
    chk("ovw_len_next", len, 100);
    do_reset();
    period_int = 21'd10;
    enable = 1'b1;
    step();
    corr = -22'sd3;
    corr_valid = 1'b1;
    step();
    corr_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_outs", int'({period_start, fb_phase, corr_ack, sat}), 0);
    reset = 1'b0;
    step();
    chk("rst_restart", int'(period_start), 1);
    chk("rst_restart_ack", int'(corr_ack), 0);
    meas(len, hi);
    chk("rst_len", len, 10);
    chk("rst_ack_next", int'(corr_ack), 0);
    do_reset();
    period_int = 21'd10;
    period_frac = 10'd256;
    enable = 1'b1;
    step();
    meas(len, hi);
    meas(len, hi);
    step();
    step();
    corr = 22'sd4;
    corr_valid = 1'b1;
    step();
    corr_valid = 1'b0;
    enable = 1'b0;
    step();
    chk("dis_outs", int'({period_start, fb_phase, corr_ack, sat}), 0);
    enable = 1'b1;
    step();
    chk("dis_restart", int'(period_start), 1);
    chk("dis_restart_ack", int'(corr_ack), 0);
    for (int i = 0; i < 4; i++) begin
      meas(len, hi);
      chk($sformatf("dis_len%0d", i), len, exp_f[i]);
      chk($sformatf("dis_ack%0d", i), int'(corr_ack), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frac_phase_gen.md
Name: frac_phase_gen

Overview:
Fractional-period pulse generator that produces the fb_phase square wave consumed by phase_det. It closes the loop: the loop filter drives a signed per-period correction, and the block turns nominal integer+fractional period words into a clock-accurate edge train. It sits between the loop filter and the phase detector's fb_phase input.

Parameters:
WIDTH_TMR, 21, integer period width in clk cycles
WIDTH_FRAC, 10, fractional period width (LSB = 2^-WIDTH_FRAC cycle)
WIDTH_ERR, 22, signed correction width (matches phase_det err)
MIN_PERIOD, 4, minimum loaded period in cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  run request; low forces IDLE
period_int  in  WIDTH_TMR  nominal integer period (cycles)
period_frac  in  WIDTH_FRAC  nominal fractional period
corr  in  WIDTH_ERR signed  one-shot period correction (cycles)
corr_valid  in  1  strobe, latches corr
corr_ack  out  1  one-cycle pulse: pending correction consumed
fb_phase  out  1  generated phase output, registered
period_start  out  1  one-cycle pulse on the first cycle of each period
sat  out  1  one-cycle pulse with period_start when the loaded length was clamped

Behaviour:
- Reset (synchronous, dominant over everything): state=IDLE, cnt=0, acc=0, pending=0, all outputs 0.
- States: IDLE, RUN. IDLE->RUN when enable=1; RUN->IDLE when enable=0, taking effect the same cycle. Entering IDLE clears cnt, acc and pending and drives outputs 0; it generates no partial period and no corr_ack.
- Period load, performed at the first RUN cycle and whenever cnt==0 in RUN:
  - {carry, acc} <= acc + period_frac, at WIDTH_FRAC+1 bits.
  - L = period_int + carry + (pending ? corr_q : 0), computed signed at WIDTH_TMR+2 bits.
  - L is clamped to [MIN_PERIOD, 2^WIDTH_TMR-1]. sat=1 if clamped.
  - cnt <= L-1. H <= L>>1. pending <= 0. corr_ack=1 if pending was set.
- Timing: enable sampled high at cycle t -> period_start=1 and fb_phase=1 at t+1. Period length is exactly L cycles, from period_start to the next period_start.
- fb_phase is high for the first H cycles of each period and low for the remaining L-H. Its rising edge is coincident with period_start.
- Correction capture: corr_valid=1 -> corr_q <= corr, pending <= 1.
  - A new corr_valid while pending overwrites corr_q (latest wins).
  - corr_valid on a load cycle is not applied to that period; it stays pending for the next period.
- Each correction affects exactly one period. The fractional accumulator is never altered by corr.
- period_int and period_frac are sampled only at load, so mid-period changes apply from the next period.
- period_int < MIN_PERIOD with zero corr clamps to MIN_PERIOD and asserts sat.

Decomposition:
- Package frac_pwm_pkg holds:
  - WIDTH_TMR/WIDTH_FRAC/WIDTH_ERR defaults and MIN_PERIOD
  - state enum {IDLE, RUN}
  - clamp helper function
- Sub-module frac_accum holds the fractional accumulator with carry out. Inputs: clk, reset, clr, step, frac. Outputs: carry, acc.
- Top level holds the FSM, down-counter, correction latch and output registers.

Test Plan:
1. Basic period: period_int=10, period_frac=0, enable=1 -> period_start every 10 cycles; fb_phase high 5 cycles, low 5; first period_start 1 cycle after enable.
2. Fractional stepping: period_int=10, period_frac=256 -> periods repeat 10,10,10,11 (mean 10.25); acc returns to 0 after every 4 periods.
3. Correction: corr=-3 strobed mid-period with period_int=100 -> next period 97 with corr_ack on its period_start; the following period is 100. Overwrite case: strobing corr=+5 then +7 before the load -> the next period is 107 with a single corr_ack.
4. Corr on load cycle: corr_valid coincident with period_start -> the current period is unchanged; the next period includes corr.
5. Saturation: period_int=5, corr=-20 -> L=4, sat pulse, fb_phase high 2 / low 2. Second case: period_int=2^21-2, corr=+10 -> L=2^21-1 with sat.
6. Reset/disable mid-period: reset at cycle 3 of a 10-cycle period -> all outputs 0 next cycle, pending correction lost. enable low then high -> a fresh period starts at acc=0 with no corr_ack.
